// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard detection and forwarding control for a classic five-stage in-order
// pipeline (IF, ID, EX, MEM, WB). The unit keeps its own shadow copy of the
// register-index fields that travel down the datapath. Forward selects,
// stalls and flushes are derived from that shadow pipeline and from the
// instruction currently in Decode.
//
// Parameters
//   RegAddrWidth  width of a register index (default 5, i.e. 32 registers)
//
// Ports
//   clk           single clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   rs1_d, rs2_d  source register indices of the Decode instruction
//   rd_d          destination register index of the Decode instruction
//   reg_write_d   Decode instruction writes the register file
//   result_src_d  Decode result source: 00 ALU, 01 load, 10 PC+4, 11 as ALU
//   pc_src_e      taken branch/jump resolved in Execute this cycle
//   forward_a_e   SrcA mux select: 00 regfile, 01 WB result, 10 MEM ALU result
//   forward_b_e   SrcB mux select, same encoding
//   stall_f       hold the PC
//   stall_d       hold the IF/ID register
//   flush_d       clear the IF/ID register
//   flush_e       clear the ID/EX register
//   stall_cnt     saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RegAddrWidth-1:0] rs1_d,
  input  logic [RegAddrWidth-1:0] rs2_d,
  input  logic [RegAddrWidth-1:0] rd_d,
  input  logic                    reg_write_d,
  input  logic [1:0]              result_src_d,
  input  logic                    pc_src_e,
  output logic [1:0]              forward_a_e,
  output logic [1:0]              forward_b_e,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    flush_d,
  output logic                    flush_e,
  output logic [15:0]             stall_cnt
);

  typedef logic [RegAddrWidth-1:0] reg_idx_t;

  localparam reg_idx_t   RegZero    = '0;
  localparam logic [1:0] ResultLoad = 2'b01;
  localparam logic [1:0] FwdReg     = 2'b00;
  localparam logic [1:0] FwdWb      = 2'b01;
  localparam logic [1:0] FwdMem     = 2'b10;
  localparam logic [15:0] CntMax    = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Shadow pipeline state
  // ---------------------------------------------------------------------------
  // ID/EX
  reg_idx_t rs1_e_q, rs2_e_q, rd_e_q;
  logic     reg_write_e_q, load_e_q;
  // EX/MEM
  reg_idx_t rd_m_q;
  logic     reg_write_m_q;
  // MEM/WB
  reg_idx_t rd_w_q;
  logic     reg_write_w_q;
  // Stall statistics
  logic [15:0] stall_cnt_q;

  // Next-state for ID/EX
  reg_idx_t rs1_e_d, rs2_e_d, rd_e_d;
  logic     reg_write_e_d, load_e_d;
  logic [15:0] stall_cnt_d;

  logic lw_stall;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  // Memory stage wins over Writeback because it holds the younger result.
  // Index 0 is hard-wired to zero and must never be forwarded.
  function automatic logic [1:0] fwd_sel(
    input reg_idx_t rs,
    input reg_idx_t rd_m,
    input logic     wr_m,
    input reg_idx_t rd_w,
    input logic     wr_w
  );
    logic [1:0] sel;
    sel = FwdReg;
    if (rs != RegZero) begin
      if (wr_m && (rd_m == rs)) begin
        sel = FwdMem;
      end else if (wr_w && (rd_w == rs)) begin
        sel = FwdWb;
      end
    end
    return sel;
  endfunction

  // Driven purely from registered state: no path from the Decode inputs.
  always_comb begin
    forward_a_e = fwd_sel(rs1_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
    forward_b_e = fwd_sel(rs2_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
  end

  // ---------------------------------------------------------------------------
  // Load-use stall and flush control
  // ---------------------------------------------------------------------------
  // The shadow ID/EX registers are cleared asynchronously by reset, so
  // lw_stall drops the moment rst_n falls.
  always_comb begin
    lw_stall = load_e_q && (rd_e_q != RegZero) &&
               ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));
  end

  always_comb begin
    stall_f = lw_stall;
    stall_d = lw_stall;
    flush_d = pc_src_e;
    // A stall injects a bubble into EX; a redirect kills the EX instruction.
    flush_e = lw_stall | pc_src_e;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_e_d       = rs1_d;
    rs2_e_d       = rs2_d;
    rd_e_d        = rd_d;
    reg_write_e_d = reg_write_d;
    load_e_d      = (result_src_d == ResultLoad);
    if (flush_e) begin
      rs1_e_d       = RegZero;
      rs2_e_d       = RegZero;
      rd_e_d        = RegZero;
      reg_write_e_d = 1'b0;
      load_e_d      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lw_stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // EX/MEM and MEM/WB are never stalled or flushed: a bubble simply flows
  // down from ID/EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e_q       <= RegZero;
      rs2_e_q       <= RegZero;
      rd_e_q        <= RegZero;
      reg_write_e_q <= 1'b0;
      load_e_q      <= 1'b0;
      rd_m_q        <= RegZero;
      reg_write_m_q <= 1'b0;
      rd_w_q        <= RegZero;
      reg_write_w_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
    end else begin
      rs1_e_q       <= rs1_e_d;
      rs2_e_q       <= rs2_e_d;
      rd_e_q        <= rd_e_d;
      reg_write_e_q <= reg_write_e_d;
      load_e_q      <= load_e_d;
      rd_m_q        <= rd_e_q;
      reg_write_m_q <= reg_write_e_q;
      rd_w_q        <= rd_m_q;
      reg_write_w_q <= reg_write_m_q;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_fwd_a_legal : assert property (@(posedge clk) disable iff (!rst_n)
                                   forward_a_e != 2'b11);
  a_fwd_b_legal : assert property (@(posedge clk) disable iff (!rst_n)
                                   forward_b_e != 2'b11);
  a_stall_bubble : assert property (@(posedge clk) disable iff (!rst_n)
                                    lw_stall |-> flush_e);

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Self-checking bench for hazard_unit. Each scenario task builds a short
// table of Decode-stage instructions together with the outputs expected in
// that cycle. Inputs are driven on the falling edge, the expected outputs are
// pushed to a scoreboard, and 1 time unit later the DUT outputs are sampled,
// the expectation is popped, and the two are compared.
// Packed output vector: {fa[1:0], fb[1:0], sf, sd, fd, fe, cnt[15:0]}.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d;
  logic [1:0]  result_src_d;
  logic        pc_src_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
    logic        pc;
    logic [23:0] ev;
  } stim_t;

  typedef struct {
    logic [23:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  hazard_unit #(.RegAddrWidth(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .reg_write_d  (reg_write_d),
    .result_src_d (result_src_d),
    .pc_src_e     (pc_src_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic fd,
                                     input logic fe, input logic [15:0] cnt);
    return {fa, fb, sf, sd, fd, fe, cnt};
  endfunction

  function automatic stim_t st(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                               input logic pc, input logic [23:0] ev);
    stim_t s;
    s.rst = rst; s.r1 = r1; s.r2 = r2; s.rd = rd;
    s.rw = rw; s.rs = rs; s.pc = pc; s.ev = ev;
    return s;
  endfunction

  function automatic logic [23:0] observe();
    return {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt};
  endfunction

  // Drive one Decode instruction on the falling edge and record its expectation.
  task automatic drive(input stim_t s, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n        = s.rst;
    rs1_d        = s.r1;
    rs2_d        = s.r2;
    rd_d         = s.rd;
    reg_write_d  = s.rw;
    result_src_d = s.rs;
    pc_src_e     = s.pc;
    e.v  = s.ev;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;
    reg_write_d = 1'b0; result_src_d = 2'b00; pc_src_e = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset holds state across clock edges; flush follows pc_src_e; the first
  // edge after release samples normally.
  task automatic test_reset();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    t.push_back(st(0, 1, 0, 3, 1, 2'b01, 1, mk(0, 0, 0, 0, 1, 1, 0)));  // lw x3
    t.push_back(st(0, 3, 0, 4, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // add rs1=x3
    t.push_back(st(0, 3, 3, 4, 1, 2'b00, 1, mk(0, 0, 0, 0, 1, 1, 0)));
    t.push_back(st(1, 1, 0, 3, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // lw x3, released
    t.push_back(st(1, 3, 0, 4, 1, 2'b00, 0, mk(0, 0, 1, 1, 0, 1, 0)));  // load-use
    t.push_back(st(1, 3, 0, 4, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 1)));  // held add
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(1, 0, 0, 0, 0, 0, 1)));  // WB forward
    foreach (t[i]) begin
      drive(t[i], $sformatf("reset[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
  endtask

  // ALU result forwarded from MEM, then from WB for a consumer two behind.
  task automatic test_alu_forward();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    do_reset();
    t.push_back(st(1, 1, 2, 5, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // add x5
    t.push_back(st(1, 5, 0, 6, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // rs1=x5
    t.push_back(st(1, 5, 5, 7, 1, 2'b00, 0, mk(2, 0, 0, 0, 0, 0, 0)));  // rs1,rs2=x5
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(1, 1, 0, 0, 0, 0, 0)));
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      drive(t[i], $sformatf("alu_fwd[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
  endtask

  // Two writers of x7 in flight: MEM wins. A non-writing producer never forwards.
  task automatic test_double_match();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    do_reset();
    t.push_back(st(1, 1, 2, 7, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // add x7
    t.push_back(st(1, 3, 4, 7, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // add x7
    t.push_back(st(1, 0, 7, 8, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // rs2=x7
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 2, 0, 0, 0, 0, 0)));
    t.push_back(st(1, 1, 0, 9, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // no write rd=9
    t.push_back(st(1, 9, 0, 10, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0))); // rs1=x9
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      drive(t[i], $sformatf("double[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
  endtask

  // One-cycle load-use stall on rs1 and on rs2, then WB forwarding.
  task automatic test_load_use();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    do_reset();
    t.push_back(st(1, 1, 0, 3, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // lw x3
    t.push_back(st(1, 3, 0, 4, 1, 2'b00, 0, mk(0, 0, 1, 1, 0, 1, 0)));  // add rs1=x3
    t.push_back(st(1, 3, 0, 4, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 1)));  // held
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(1, 0, 0, 0, 0, 0, 1)));
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 1)));
    t.push_back(st(1, 1, 0, 4, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, 1)));  // lw x4
    t.push_back(st(1, 0, 4, 5, 1, 2'b00, 0, mk(0, 0, 1, 1, 0, 1, 1)));  // rs2=x4
    t.push_back(st(1, 0, 4, 5, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 2)));  // held
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 0, 2)));
    foreach (t[i]) begin
      drive(t[i], $sformatf("load_use[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
  endtask

  // x0 never stalls or forwards; result_src 11 and 10 are not loads.
  task automatic test_x0_and_src();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    do_reset();
    t.push_back(st(1, 0, 0, 0, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // lw x0
    t.push_back(st(1, 0, 0, 5, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // rs1=x0
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));
    t.push_back(st(1, 1, 0, 3, 1, 2'b11, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // src 11 -> x3
    t.push_back(st(1, 3, 3, 6, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // no stall
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(2, 2, 0, 0, 0, 0, 0)));
    t.push_back(st(1, 0, 0, 8, 1, 2'b10, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // jal x8
    t.push_back(st(1, 8, 0, 9, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // no stall
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(2, 0, 0, 0, 0, 0, 0)));
    foreach (t[i]) begin
      drive(t[i], $sformatf("x0_src[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
  endtask

  // Redirect coinciding with a load-use stall, then a redirect alone.
  task automatic test_simultaneous();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    do_reset();
    t.push_back(st(1, 1, 0, 3, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, 0)));  // lw x3
    t.push_back(st(1, 3, 0, 4, 1, 2'b00, 1, mk(0, 0, 1, 1, 1, 1, 0)));  // both
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 1)));  // ID/EX zero
    t.push_back(st(1, 1, 0, 9, 1, 2'b00, 1, mk(0, 0, 0, 0, 1, 1, 1)));  // killed x9
    t.push_back(st(1, 9, 0, 10, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 1)));
    t.push_back(st(1, 0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 0, 1)));  // no fwd of x9
    foreach (t[i]) begin
      drive(t[i], $sformatf("simul[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
  endtask

  // Counter preloaded near the top, pushed through saturation, then an
  // asynchronous reset in the middle of a stall cycle.
  task automatic test_saturate_reset();
    stim_t t[$];
    exp_t  e;
    logic [23:0] got;
    logic [23:0] want;
    int c;
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFC;
    @(negedge clk);
    release dut.stall_cnt_q;
    for (int k = 0; k < 6; k++) begin
      c = 'hFFFC + k;
      if (c > 'hFFFF) c = 'hFFFF;
      t.push_back(st(1, 1, 0, 3, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, c[15:0])));
      t.push_back(st(1, 3, 0, 4, 1, 2'b00, 0, mk(0, 0, 1, 1, 0, 1, c[15:0])));
    end
    foreach (t[i]) begin
      drive(t[i], $sformatf("sat[%0d]", i));
      #1;
      got = observe();
      e = sb.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.nm, got, e.v);
      end
    end
    // Still inside the last stall cycle.
    #2;
    rst_n = 1'b0;
    #1;
    got  = observe();
    want = mk(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h", got, want);
    end
    pc_src_e = 1'b1;
    #1;
    got  = observe();
    want = mk(0, 0, 0, 0, 1, 1, 0);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_flush got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
    got = observe();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_hold got=%h want=%h", got, want);
    end
    pc_src_e = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;
    reg_write_d = 1'b0; result_src_d = 2'b00; pc_src_e = 1'b0;
    test_reset();
    test_alu_forward();
    test_double_match();
    test_load_use();
    test_x0_and_src();
    test_simultaneous();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter RegAddrWidth, default 5, giving the register-index width.
REQ-002 `clk` input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 `rst_n` input, 1 bit: asynchronous, active-low reset.
REQ-004 `rs1_d`, `rs2_d` inputs, RegAddrWidth bits: source register indices of the instruction in Decode.
REQ-005 `rd_d` input, RegAddrWidth bits: destination register index of the instruction in Decode.
REQ-006 `reg_write_d` input, 1 bit: the Decode instruction writes the register file.
REQ-007 `result_src_d` input, 2 bits: Decode result source (00 ALU, 01 load, 10 PC+4; 11 treated as 00).
REQ-008 `pc_src_e` input, 1 bit: a taken branch or jump is resolved in Execute this cycle.
REQ-009 `forward_a_e`, `forward_b_e` outputs, 2 bits each: select for the Execute-stage SrcA/SrcB 4:1 operand muxes (00 register file, 01 Writeback result, 10 Memory ALU result, 11 never driven).
REQ-010 `stall_f`, `stall_d` outputs, 1 bit each: hold the PC and the IF/ID register.
REQ-011 `flush_d`, `flush_e` outputs, 1 bit each: clear the IF/ID and ID/EX registers.
REQ-012 `stall_cnt` output, 16 bits: saturating count of load-use stall cycles.

Function
REQ-013 The unit SHALL keep an internal shadow pipeline that mirrors the datapath: ID/EX (rs1_e, rs2_e, rd_e, reg_write_e, load_e), EX/MEM (rd_m, reg_write_m) and MEM/WB (rd_w, reg_write_w).
REQ-014 On each clock edge, ID/EX SHALL capture rs1_d, rs2_d, rd_d, reg_write_d, and load_e = (result_src_d == 01); when flush_e = 1 it SHALL capture all zeros instead.
REQ-015 On each clock edge, EX/MEM SHALL capture the ID/EX rd_e and reg_write_e, and MEM/WB SHALL capture the EX/MEM contents; these registers are never stalled or flushed.
REQ-016 forward_a_e SHALL be 10 when reg_write_m = 1, rd_m == rs1_e and rs1_e != 0; otherwise 01 when reg_write_w = 1, rd_w == rs1_e and rs1_e != 0; otherwise 00.
REQ-017 forward_b_e SHALL follow the same rule as REQ-016 using rs2_e.
REQ-018 When both the Memory and Writeback stages match, the Memory stage (10) SHALL take priority.
REQ-019 Forward selects SHALL be combinational from registered state only, with no combinational path from D-stage inputs.
REQ-020 lw_stall SHALL be asserted when load_e = 1, rd_e != 0, and (rd_e == rs1_d or rd_e == rs2_d).
REQ-021 stall_f and stall_d SHALL each equal lw_stall.
REQ-022 flush_d SHALL equal pc_src_e.
REQ-023 flush_e SHALL equal lw_stall OR pc_src_e.
REQ-024 When lw_stall and pc_src_e are both asserted, all four stall/flush outputs SHALL be 1; the datapath gives flush priority over stall on IF/ID.
REQ-025 A load-use stall SHALL last exactly one cycle: the inserted ID/EX bubble clears load_e, so lw_stall deasserts on the next cycle and forwarding then selects 01 from Writeback two cycles later.
REQ-026 stall_cnt SHALL increment by 1 on each clock edge where lw_stall = 1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-027 Register index 0 SHALL never cause forwarding or a stall.

Reset
REQ-028 While rst_n = 0, all shadow registers and stall_cnt SHALL be 0, regardless of clk.
REQ-029 During reset, forward_a_e and forward_b_e SHALL be 00 and stall_f, stall_d SHALL be 0.
REQ-030 During reset, flush_d and flush_e SHALL track pc_src_e combinationally.
REQ-031 Reset asserted mid-stall SHALL clear lw_stall immediately (asynchronously) and zero stall_cnt.
REQ-032 The first edge after rst_n rises SHALL sample the D-stage inputs normally.

Verification
REQ-033 ALU forwarding: add x5 in D, then add using rs1 = x5 on the next cycle -> when the consumer is in E, forward_a_e = 10, and 01 one cycle later for a consumer two behind.
REQ-034 Double match: x7 written by two consecutive instructions, consumer rs2 = x7 -> forward_b_e = 10, not 01.
REQ-035 Load-use: lw x3 followed by `add rs1 = x3` -> stall_f = stall_d = flush_e = 1 for exactly one cycle, stall_cnt goes 0 to 1, then forward_a_e = 01.
REQ-036 x0 case: lw x0 followed by a consumer with rs1 = 0 -> no stall and forward = 00.
REQ-037 Simultaneous events: pc_src_e = 1 in the same cycle as lw_stall -> flush_d = flush_e = stall_f = stall_d = 1; the next cycle's ID/EX shadow is zero.
REQ-038 Saturation and reset: force 65 540 stall cycles -> stall_cnt holds at 16'hFFFF; then pulse rst_n low mid-cycle -> stall_cnt is 0 and forward selects are 00 immediately.
